// File: rtl/key_debounce_pkg.sv
// Shared definitions for the push-button debouncer: per-key FSM state
// encoding, default timing constants and a counter-width helper.
package key_pkg;

  // Per-key debounce FSM states
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;

  // 20 ms stable time and 1 s long-press time at 50 MHz
  localparam int CNT_MAX_DEF  = 1000000;
  localparam int LONG_MAX_DEF = 50000000;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchronizer, debounce FSM with stable-sample
// counter, registered level/press/release outputs and, when
// KEY_LONG_PRESS_EN is defined, a saturating hold counter driving long_o.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int CNT_MAX  = CNT_MAX_DEF,
  parameter int LONG_MAX = LONG_MAX_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic key_i,
  output logic key_state_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int            CW       = cnt_width(CNT_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  // The acceptance compare needs at least two counter values to be meaningful.
  if (CNT_MAX < 2 || LONG_MAX < 2) begin : g_param_chk
    $error("key_debounce_ch: CNT_MAX and LONG_MAX must be at least 2");
  end

  logic          sync_p0;
  logic          sync_p1;
  logic          key_act;
  key_state_e    state;
  key_state_e    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          press_nxt;
  logic          release_nxt;
  logic          level_nxt;

  // Two-stage synchronizer; resets to the released level (key_i high)
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= key_i;
      sync_p1 <= sync_p0;
    end
  end

  // --- stage boundary: synchronized, active-high key seen by the FSM ---
  assign key_act = ~sync_p1;

  // Next-state, counter and pulse decode; counter stays 0 outside WAIT states
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = '0;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (key_act) state_nxt = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!key_act) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = PRESSED;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!key_act) state_nxt = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (key_act) begin
          state_nxt = PRESSED;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = IDLE;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // The debounced level is high from acceptance of a press until acceptance
  // of the release, i.e. in PRESSED and RELEASE_WAIT.
  assign level_nxt = (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);

  // FSM state, counter and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= '0;
      key_state_o <= 1'b0;
      press_o     <= 1'b0;
      release_o   <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      key_state_o <= level_nxt;
      press_o     <= press_nxt;
      release_o   <= release_nxt;
    end
  end

`ifdef KEY_LONG_PRESS_EN
  localparam int            HW        = cnt_width(LONG_MAX);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_MAX - 1);

  logic [HW-1:0] hold;
  logic          long_done;

  // Hold counter runs only while PRESSED and the key is still down; it
  // saturates at HOLD_LAST and long_done blocks any repeat pulse. Leaving
  // PRESSED (into RELEASE_WAIT) clears both, so a bounce back restarts at 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold      <= '0;
      long_done <= 1'b0;
      long_o    <= 1'b0;
    end else if ((state == PRESSED) && key_act) begin
      if (hold != HOLD_LAST) hold <= hold + 1'b1;
      long_o <= (hold == HOLD_LAST) && !long_done;
      if (hold == HOLD_LAST) long_done <= 1'b1;
    end else begin
      hold      <= '0;
      long_done <= 1'b0;
      long_o    <= 1'b0;
    end
  end
`else
  assign long_o = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// Multi-key push-button debouncer: KEY_NUM independent channels, each
// turning a raw active-low key into a clean level plus press/release
// pulses. Optional long-press detection is enabled by KEY_LONG_PRESS_EN.
module key_debounce
  import key_pkg::*;
#(
  parameter int KEY_NUM  = 4,
  parameter int CNT_MAX  = CNT_MAX_DEF,
  parameter int LONG_MAX = LONG_MAX_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [KEY_NUM-1:0] key_i,
  output logic [KEY_NUM-1:0] key_state_o,
  output logic [KEY_NUM-1:0] press_o,
  output logic [KEY_NUM-1:0] release_o,
  output logic [KEY_NUM-1:0] long_o
);

  // One fully independent channel per key
  for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
    key_debounce_ch #(
      .CNT_MAX  (CNT_MAX),
      .LONG_MAX (LONG_MAX)
    ) u_ch (
      .clk         (clk),
      .rstn        (rstn),
      .key_i       (key_i[i]),
      .key_state_o (key_state_o[i]),
      .press_o     (press_o[i]),
      .release_o   (release_o[i]),
      .long_o      (long_o[i])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with CNT_MAX = 8, LONG_MAX = 32, 4 keys.
// Pulse latency from a raw edge is 2 + 1 + 8 = 11 cycles; long_o follows
// press_o by 32 cycles when KEY_LONG_PRESS_EN is defined.
module tb_key_debounce;
  import key_pkg::*;

  localparam int KN = 4;
  localparam int CM = 8;
  localparam int LM = 32;

  logic          clk = 1'b0;
  logic          rstn;
  logic [KN-1:0] key_i;
  logic [KN-1:0] key_state_o;
  logic [KN-1:0] press_o;
  logic [KN-1:0] release_o;
  logic [KN-1:0] long_o;

  int n_tests = 0;
  int n_fail  = 0;

  key_debounce #(
    .KEY_NUM  (KN),
    .CNT_MAX  (CM),
    .LONG_MAX (LM)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .key_i       (key_i),
    .key_state_o (key_state_o),
    .press_o     (press_o),
    .release_o   (release_o),
    .long_o      (long_o)
  );

  always #5 clk = ~clk;

  // Advance one clock; sample and drive 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic bad;
    bad   = 1'b0;
    rstn  = 1'b0;
    key_i = 4'hF;
    for (int i = 0; i < 5; i++) begin
      step();
      n_tests++;
      if ({key_state_o, press_o, release_o, long_o} !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got %h expected 0000", i,
                 {key_state_o, press_o, release_o, long_o});
      end
    end
    n_tests++;
    if (dut.g_ch[0].u_ch.state !== IDLE) begin
      n_fail++; $display("FAIL reset_state0: got %0d expected %0d", dut.g_ch[0].u_ch.state, IDLE);
    end
    n_tests++;
    if (dut.g_ch[3].u_ch.state !== IDLE) begin
      n_fail++; $display("FAIL reset_state3: got %0d expected %0d", dut.g_ch[3].u_ch.state, IDLE);
    end
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if ({key_state_o, press_o, release_o, long_o} !== 16'h0) bad = 1'b1;
    end
    n_tests++;
    if (bad !== 1'b0) begin
      n_fail++; $display("FAIL idle_outputs: got nonzero output expected all 0");
    end
  endtask

  task automatic test_clean_press();
    int cnt, at, other;
    cnt = 0; at = -1; other = 0;
    key_i[0] = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (press_o[0]) begin cnt++; at = k; end
      if (press_o[3:1] != 3'b000 || release_o != 4'h0) other++;
    end
    n_tests++;
    if (cnt !== 1) begin n_fail++; $display("FAIL press0_count: got %0d expected 1", cnt); end
    n_tests++;
    if (at !== 11) begin n_fail++; $display("FAIL press0_latency: got %0d expected 11", at); end
    n_tests++;
    if (other !== 0) begin n_fail++; $display("FAIL press0_spurious: got %0d expected 0", other); end
    n_tests++;
    if (key_state_o !== 4'b0001) begin
      n_fail++; $display("FAIL press0_level: got %b expected 0001", key_state_o);
    end
  endtask

  task automatic test_release_bounce();
    int rcnt, at, pcnt;
    rcnt = 0; at = -1; pcnt = 0;
    key_i[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      if (release_o[0]) rcnt++;
      if (press_o[0]) pcnt++;
    end
    key_i[0] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      if (release_o[0]) rcnt++;
      if (press_o[0]) pcnt++;
    end
    key_i[0] = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (release_o[0]) begin rcnt++; at = k; end
      if (press_o[0]) pcnt++;
    end
    n_tests++;
    if (rcnt !== 1) begin n_fail++; $display("FAIL release0_count: got %0d expected 1", rcnt); end
    n_tests++;
    if (at !== 11) begin n_fail++; $display("FAIL release0_latency: got %0d expected 11", at); end
    n_tests++;
    if (pcnt !== 0) begin n_fail++; $display("FAIL release0_repress: got %0d expected 0", pcnt); end
    n_tests++;
    if (key_state_o !== 4'b0000) begin
      n_fail++; $display("FAIL release0_level: got %b expected 0000", key_state_o);
    end
  endtask

  task automatic test_bounce_reject();
    int  pcnt;
    logic lvl;
    pcnt = 0; lvl = 1'b0;
    for (int k = 0; k < 36; k++) begin
      // low 5, high 1, low 5, then high for the rest
      key_i[1] = (k < 5) ? 1'b0 : (k < 6) ? 1'b1 : (k < 11) ? 1'b0 : 1'b1;
      step();
      if (press_o[1]) pcnt++;
      if (key_state_o[1]) lvl = 1'b1;
    end
    n_tests++;
    if (pcnt !== 0) begin n_fail++; $display("FAIL bounce1_press: got %0d expected 0", pcnt); end
    n_tests++;
    if (lvl !== 1'b0) begin n_fail++; $display("FAIL bounce1_level: got %b expected 0", lvl); end
  endtask

  task automatic test_long_simul();
    int p2, p3, pc2, pc3, l2, l3, lc2, lc3, rat, rc;
    p2 = -1; p3 = -1; pc2 = 0; pc3 = 0; l2 = -1; l3 = -1; lc2 = 0; lc3 = 0;
    rat = -1; rc = 0;
    key_i[3:2] = 2'b00;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (press_o[2]) begin pc2++; p2 = k; end
      if (press_o[3]) begin pc3++; p3 = k; end
      if (long_o[2])  begin lc2++; l2 = k; end
      if (long_o[3])  begin lc3++; l3 = k; end
    end
    n_tests++;
    if (p2 !== 11 || p3 !== 11) begin
      n_fail++; $display("FAIL simul_press_cycle: got %0d/%0d expected 11/11", p2, p3);
    end
    n_tests++;
    if (pc2 !== 1 || pc3 !== 1) begin
      n_fail++; $display("FAIL simul_press_count: got %0d/%0d expected 1/1", pc2, pc3);
    end
    n_tests++;
    if (key_state_o !== 4'b1100) begin
      n_fail++; $display("FAIL simul_level: got %b expected 1100", key_state_o);
    end
`ifdef KEY_LONG_PRESS_EN
    n_tests++;
    if (l2 !== 43 || l3 !== 43) begin
      n_fail++; $display("FAIL long_cycle: got %0d/%0d expected 43/43", l2, l3);
    end
    n_tests++;
    if (lc2 !== 1 || lc3 !== 1) begin
      n_fail++; $display("FAIL long_count: got %0d/%0d expected 1/1", lc2, lc3);
    end
`else
    n_tests++;
    if (lc2 !== 0 || lc3 !== 0) begin
      n_fail++; $display("FAIL long_tied: got %0d/%0d expected 0/0", lc2, lc3);
    end
`endif
    key_i[3:2] = 2'b11;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (release_o[3:2] == 2'b11) begin rc++; rat = k; end
    end
    n_tests++;
    if (rc !== 1 || rat !== 11) begin
      n_fail++; $display("FAIL simul_release: got count %0d cycle %0d expected 1 at 11", rc, rat);
    end
  endtask

  task automatic test_reset_mid_press();
    int pcnt, at;
    pcnt = 0; at = -1;
    key_i[2] = 1'b0;
    for (int k = 0; k < 8; k++) step();
    n_tests++;
    if (dut.g_ch[2].u_ch.state !== PRESS_WAIT || dut.g_ch[2].u_ch.cnt !== 3'd5) begin
      n_fail++; $display("FAIL midpress_setup: got state %0d cnt %0d expected %0d 5",
                         dut.g_ch[2].u_ch.state, dut.g_ch[2].u_ch.cnt, PRESS_WAIT);
    end
    rstn = 1'b0;
    #1;
    n_tests++;
    if ({key_state_o, press_o} !== 8'h00) begin
      n_fail++; $display("FAIL midpress_async_clear: got %h expected 00", {key_state_o, press_o});
    end
    for (int k = 0; k < 2; k++) begin
      step();
      if (press_o[2]) pcnt++;
    end
    rstn = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (press_o[2]) begin pcnt++; at = k; end
    end
    n_tests++;
    if (pcnt !== 1) begin n_fail++; $display("FAIL midpress_count: got %0d expected 1", pcnt); end
    n_tests++;
    if (at !== 11) begin n_fail++; $display("FAIL midpress_latency: got %0d expected 11", at); end
    n_tests++;
    if (key_state_o !== 4'b0100) begin
      n_fail++; $display("FAIL midpress_level: got %b expected 0100", key_state_o);
    end
  endtask

  initial begin
    rstn  = 1'b0;
    key_i = 4'hF;
    test_reset();
    test_clean_press();
    test_release_bounce();
    test_bounce_reject();
    test_long_simul();
    test_reset_mid_press();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Input-side counterpart to the board's LED output path.
- Takes raw, bouncy, active-low push-button inputs and synchronizes each to clk.
- Debounces each key independently with a per-key counter FSM.
- Emits a clean level, a one-cycle press pulse and a one-cycle release pulse per key; these drive LED pattern and mode control downstream.

Parameters:
- KEY_NUM, 4, number of independent keys.
- CNT_MAX, 1000000, stable-sample count required to accept a level change (20 ms at 50 MHz).
- LONG_MAX, 50000000, held-cycles threshold for a long press (1 s at 50 MHz); used only with the optional feature.

Ports:
- clk  input  1  system clock, 50 MHz.
- rstn  input  1  asynchronous active-low reset.
- key_i  input  KEY_NUM  raw keys, active-low (0 = pressed), asynchronous to clk.
- key_state_o  output  KEY_NUM  debounced level, 1 = pressed.
- press_o  output  KEY_NUM  one-cycle pulse on accepted press.
- release_o  output  KEY_NUM  one-cycle pulse on accepted release.
- long_o  output  KEY_NUM  one-cycle pulse on long press (tied 0 without the feature).

Behaviour:
- Clock and reset: one clock domain, clk. Reset is asynchronous and active-low on rstn; every flop clears immediately while rstn = 0.
- Reset values: all outputs 0; synchronizer flops 1 (released); every FSM in IDLE; counters 0.
- Synchronizer: 2-flop synchronizer per key, then invert, so s = 1 means pressed.
- Per-key FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - IDLE: s = 1 -> PRESS_WAIT with cnt = 0.
  - PRESS_WAIT: s = 1 -> cnt increments. s = 0 before acceptance -> IDLE, cnt = 0 (bounce rejected, no pulse).
  - PRESS_WAIT acceptance: cycle where cnt = CNT_MAX-1 and s = 1 -> PRESSED, cnt = 0, press_o = 1 for that single next cycle, key_state_o = 1.
  - PRESSED: s = 0 -> RELEASE_WAIT with cnt = 0.
  - RELEASE_WAIT: mirror of PRESS_WAIT with s = 0. s = 1 before acceptance -> PRESSED, no pulse. Acceptance -> IDLE, release_o pulse, key_state_o = 0.
- Latency from a clean raw edge to the pulse: 2 (sync) + 1 (state entry) + CNT_MAX cycles. This is a fixed number; the bench checks it exactly.
- Counter width: $clog2(CNT_MAX) bits, never wraps. Held at 0 outside the WAIT states.
- Keys are fully independent. Simultaneous presses on several keys give pulses in the same cycle.
- Pulses never overlap: press_o and release_o for one key are at least CNT_MAX cycles apart.
- Reset asserted mid-debounce or mid-press: no pulse is emitted. After reset release, a key still held re-runs the full press debounce and yields one press_o.
- Outputs are registered; no combinational path from key_i to any output.

Optional Feature:
- Macro KEY_LONG_PRESS_EN.
- Defined: each key gets a hold counter of $clog2(LONG_MAX) bits, running only in PRESSED.
  - On reaching LONG_MAX-1: long_o pulses once, and the counter saturates, so there is no repeat per hold.
  - The counter is cleared on entering RELEASE_WAIT. A bounce back into PRESSED restarts it from 0.
- Undefined: hold counter absent; long_o tied to 0.

Decomposition:
- Package key_pkg holds:
  - the state enum (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT, 2 bits);
  - default constants CNT_MAX_DEF = 1000000 and LONG_MAX_DEF = 50000000.
- Sub-module key_debounce_ch: one key, containing synchronizer, FSM, counters and pulse registers.
- key_debounce instantiates KEY_NUM copies via a generate loop.

Test Plan (sim parameters CNT_MAX = 8, LONG_MAX = 32, KEY_NUM = 4, KEY_LONG_PRESS_EN defined):
1. Reset then idle: rstn low 5 cycles, key_i = 4'hF held -> all outputs 0 throughout; internal state IDLE.
2. Clean press: key_i[0] 1->0 and held -> press_o[0] high exactly one cycle, 11 cycles after the edge; key_state_o = 4'b0001.
3. Bounce rejection: key_i[1] toggles low 5 cycles, high 1 cycle, low 5 cycles, then high -> press_o[1] never asserts; key_state_o[1] stays 0.
4. Release with bounce: key 0 pressed, then key_i[0] high 3 cycles, low 2 cycles, high held -> exactly one release_o[0], 11 cycles after the final rising edge.
5. Long press and simultaneity: key_i[3:2] both low from the same cycle, held 60 cycles -> press_o[3:2] = 2'b11 in the same cycle; long_o[3:2] = 2'b11 once, 32 cycles after press_o; no second long_o.
6. Reset mid-press: key 2 in PRESS_WAIT at cnt = 5, pulse rstn low -> no press_o. After rstn high with key still low, one press_o[2] occurs after full latency.
